// File: rtl/snake_step_ctrl_if.sv
// rtl/snake_step_ctrl_if.sv - button/limit inputs and head/step outputs of the snake step controller
interface snake_step_ctrl_if #(
  parameter int W = 10
);
  logic         btn_up;
  logic         btn_down;
  logic         btn_left;
  logic         btn_right;
  logic         btn_pause;
  logic [W-1:0] max_x;
  logic [W-1:0] max_y;
  logic [W-1:0] head_x;
  logic [W-1:0] head_y;
  logic [1:0]   dir;
  logic         step_pulse;
  logic         paused;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_pause, max_x, max_y,
    input  head_x, head_y, dir, step_pulse, paused
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_pause, max_x, max_y,
    output head_x, head_y, dir, step_pulse, paused
  );
endinterface

// File: rtl/snake_step_ctrl.sv
// rtl/snake_step_ctrl.sv - game-step scheduler: tick prescaler, direction buffer, wrapping head counters
module snake_step_ctrl #(
  parameter int DIV   = 25000000,
  parameter int DIV_W = 25,
  parameter int W     = 10
) (
  input  logic              clock,
  input  logic              reset,
  snake_step_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {PAUSED, RUN, STEP} state_t;

  localparam logic [1:0]       D_UP    = 2'd0;
  localparam logic [1:0]       D_DOWN  = 2'd1;
  localparam logic [1:0]       D_LEFT  = 2'd2;
  localparam logic [1:0]       D_RIGHT = 2'd3;
  localparam logic [DIV_W-1:0] TERM    = DIV_W'(DIV - 1);

  state_t           state;
  logic [DIV_W-1:0] presc;
  logic [W-1:0]     head_x;
  logic [W-1:0]     head_y;
  logic [1:0]       dir;
  logic [1:0]       pend_dir;
  logic             step_pulse;
  logic             paused;

  logic             press_any;
  logic [1:0]       press_dir;
  logic             accept;
  logic [W-1:0]     next_x;
  logic [W-1:0]     next_y;

  // Opposite directions differ only in bit 0 of the encoding.
  always_comb begin
    press_any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
    press_dir = bus.btn_up   ? D_UP   :
                bus.btn_down ? D_DOWN :
                bus.btn_left ? D_LEFT : D_RIGHT;
    accept    = press_any && (press_dir != (dir ^ 2'b01));
  end

  always_comb begin
    next_x = head_x;
    next_y = head_y;
    if (head_x > bus.max_x)
      next_x = '0;
    else if (pend_dir == D_LEFT)
      next_x = (head_x == '0) ? bus.max_x : head_x - W'(1);
    else if (pend_dir == D_RIGHT)
      next_x = (head_x >= bus.max_x) ? '0 : head_x + W'(1);
    if (head_y > bus.max_y)
      next_y = '0;
    else if (pend_dir == D_UP)
      next_y = (head_y == '0) ? bus.max_y : head_y - W'(1);
    else if (pend_dir == D_DOWN)
      next_y = (head_y >= bus.max_y) ? '0 : head_y + W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= PAUSED;
      presc      <= '0;
      head_x     <= '0;
      head_y     <= '0;
      dir        <= D_RIGHT;
      pend_dir   <= D_RIGHT;
      step_pulse <= 1'b0;
      paused     <= 1'b1;
    end else begin
      if (accept)
        pend_dir <= press_dir;
      step_pulse <= 1'b0;
      case (state)
        PAUSED: begin
          presc <= '0;
          // The resume cycle itself is count 0, so the first step lands DIV clocks later.
          if (bus.btn_pause) begin
            state  <= RUN;
            presc  <= DIV_W'(1);
            paused <= 1'b0;
          end
        end
        RUN: begin
          if (bus.btn_pause) begin
            state  <= PAUSED;
            presc  <= '0;
            paused <= 1'b1;
          end else if (presc == TERM) begin
            state      <= STEP;
            presc      <= '0;
            step_pulse <= 1'b1;
            dir        <= pend_dir;
            head_x     <= next_x;
            head_y     <= next_y;
          end else begin
            presc <= presc + DIV_W'(1);
          end
        end
        STEP: begin
          if (bus.btn_pause) begin
            state  <= PAUSED;
            presc  <= '0;
            paused <= 1'b1;
          end else begin
            state <= RUN;
            presc <= presc + DIV_W'(1);
          end
        end
        default: begin
          state  <= PAUSED;
          presc  <= '0;
          paused <= 1'b1;
        end
      endcase
    end
  end

  assign bus.head_x     = head_x;
  assign bus.head_y     = head_y;
  assign bus.dir        = dir;
  assign bus.step_pulse = step_pulse;
  assign bus.paused     = paused;
endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb/tb_snake_step_ctrl.sv - directed table and corner sequences for snake_step_ctrl
module tb_snake_step_ctrl;
  localparam int DIV   = 4;
  localparam int DIV_W = 4;
  localparam int W     = 10;

  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] P = 5'b10000;
  localparam logic [4:0] U = 5'b01000;
  localparam logic [4:0] D = 5'b00100;
  localparam logic [4:0] L = 5'b00010;

  typedef struct {
    logic [4:0]   btn;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic [1:0]   ed;
    logic         es;
    logic         ep;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  vec_t tbl [43];

  snake_step_ctrl_if #(.W(W)) bus ();

  snake_step_ctrl #(.DIV(DIV), .DIV_W(DIV_W), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(logic [4:0] b, int x, int y, int d, int s, int p);
    vec_t v;
    v.btn = b;
    v.ex  = W'(x);
    v.ey  = W'(y);
    v.ed  = 2'(d);
    v.es  = 1'(s);
    v.ep  = 1'(p);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_btn(logic [4:0] b);
    bus.btn_pause = b[4];
    bus.btn_up    = b[3];
    bus.btn_down  = b[2];
    bus.btn_left  = b[1];
    bus.btn_right = b[0];
  endtask

  function automatic logic [31:0] outs();
    return {8'd0, bus.head_x, bus.head_y, bus.dir, bus.step_pulse, bus.paused};
  endfunction

  task automatic wait_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.step_pulse && n < 40);
    if (!bus.step_pulse) begin
      checks++;
      errors++;
      $display("FAIL step_timeout got=no_step expected=step_pulse within 40 cycles");
    end
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_btn(N);
    bus.max_x = W'(7);
    bus.max_y = W'(7);

    tbl[0]  = mk(P, 0, 0, 3, 0, 0);
    tbl[1]  = mk(N, 0, 0, 3, 0, 0);
    tbl[2]  = mk(N, 0, 0, 3, 0, 0);
    tbl[3]  = mk(N, 1, 0, 3, 1, 0);
    tbl[4]  = mk(L, 1, 0, 3, 0, 0);
    tbl[5]  = mk(L | U, 1, 0, 3, 0, 0);
    tbl[6]  = mk(N, 1, 0, 3, 0, 0);
    tbl[7]  = mk(N, 1, 7, 0, 1, 0);
    tbl[8]  = mk(U, 1, 7, 0, 0, 0);
    tbl[9]  = mk(L, 1, 7, 0, 0, 0);
    tbl[10] = mk(N, 1, 7, 0, 0, 0);
    tbl[11] = mk(N, 0, 7, 2, 1, 0);
    tbl[12] = mk(L, 0, 7, 2, 0, 0);
    tbl[13] = mk(N, 0, 7, 2, 0, 0);
    tbl[14] = mk(N, 0, 7, 2, 0, 0);
    tbl[15] = mk(N, 7, 7, 2, 1, 0);
    tbl[16] = mk(D, 7, 7, 2, 0, 0);
    tbl[17] = mk(N, 7, 7, 2, 0, 0);
    tbl[18] = mk(N, 7, 7, 2, 0, 0);
    tbl[19] = mk(N, 7, 0, 1, 1, 0);
    tbl[20] = mk(5'b00001, 7, 0, 1, 0, 0);
    tbl[21] = mk(N, 7, 0, 1, 0, 0);
    tbl[22] = mk(N, 7, 0, 1, 0, 0);
    tbl[23] = mk(N, 0, 0, 3, 1, 0);
    tbl[24] = mk(N, 0, 0, 3, 0, 0);
    tbl[25] = mk(N, 0, 0, 3, 0, 0);
    tbl[26] = mk(N, 0, 0, 3, 0, 0);
    tbl[27] = mk(D, 1, 0, 3, 1, 0);
    tbl[28] = mk(N, 1, 0, 3, 0, 0);
    tbl[29] = mk(N, 1, 0, 3, 0, 0);
    tbl[30] = mk(N, 1, 0, 3, 0, 0);
    tbl[31] = mk(N, 1, 1, 1, 1, 0);
    tbl[32] = mk(L, 1, 1, 1, 0, 0);
    tbl[33] = mk(N, 1, 1, 1, 0, 0);
    tbl[34] = mk(N, 1, 1, 1, 0, 0);
    tbl[35] = mk(P, 1, 1, 1, 0, 1);
    tbl[36] = mk(D, 1, 1, 1, 0, 1);
    tbl[37] = mk(N, 1, 1, 1, 0, 1);
    tbl[38] = mk(P, 1, 1, 1, 0, 0);
    tbl[39] = mk(N, 1, 1, 1, 0, 0);
    tbl[40] = mk(N, 1, 1, 1, 0, 0);
    tbl[41] = mk(N, 1, 2, 1, 1, 0);
    tbl[42] = mk(P, 1, 2, 1, 0, 1);

    tick();
    chk("reset_state", outs(), {8'd0, 10'd0, 10'd0, 2'd3, 1'b0, 1'b1});
    tick();
    reset = 1'b0;
    tick();
    chk("idle_after_reset", outs(), {8'd0, 10'd0, 10'd0, 2'd3, 1'b0, 1'b1});

    for (int i = 0; i < 43; i++) begin
      set_btn(tbl[i].btn);
      tick();
      set_btn(N);
      chk($sformatf("row%0d", i), outs(),
          {8'd0, tbl[i].ex, tbl[i].ey, tbl[i].ed, tbl[i].es, tbl[i].ep});
    end

    // Async reset while paused with non-zero head, then out-of-range and zero-max axes.
    reset = 1'b1;
    #1;
    chk("async_reset_mid_run", outs(), {8'd0, 10'd0, 10'd0, 2'd3, 1'b0, 1'b1});
    tick();
    reset = 1'b0;
    bus.max_x = W'(15);
    bus.max_y = W'(15);
    set_btn(P);
    tick();
    set_btn(N);
    for (int k = 1; k <= 9; k++) begin
      wait_step(n);
      chk($sformatf("period_%0d", k), n, (k == 1) ? DIV - 1 : DIV);
      chk($sformatf("walk_x_%0d", k), bus.head_x, k);
    end
    set_btn(U);
    bus.max_x = W'(5);
    tick();
    set_btn(N);
    wait_step(n);
    chk("oor_x_forced_zero", {bus.head_x, bus.head_y, bus.dir}, {10'd0, 10'd15, 2'd0});
    bus.max_y = W'(0);
    wait_step(n);
    chk("oor_y_forced_zero", {bus.head_x, bus.head_y}, {10'd0, 10'd0});
    wait_step(n);
    chk("max_y_zero_stays", {bus.head_x, bus.head_y}, {10'd0, 10'd0});

    // Reset in the middle of the STEP cycle must drop step_pulse without a clock edge.
    chk("in_step_before_reset", bus.step_pulse, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_during_step", outs(), {8'd0, 10'd0, 10'd0, 2'd3, 1'b0, 1'b1});
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3 * DIV; k++) begin
      tick();
      chk($sformatf("quiet_after_reset_%0d", k), {bus.step_pulse, bus.paused}, 2'b01);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
